// File: rtl/button_pkg.sv
// Shared definitions for the debounced pushbutton reader: FSM encoding and
// default timing constants (10 MHz system clock).
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;    // 10 ms
  localparam int DEFAULT_LONG_CYCLES     = 10000000;  // 1 s

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit, with a
// configurable reset value so the output idles at the input's inactive level.
module sync2 #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= {2{RESET_VALUE}};
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/button_reader.sv
// Debounced active-low pushbutton reader: press/release/long-press strobes,
// a modulo-16 press counter and active-low LED mirror of that counter.
module button_reader
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic [3:0] press_count,
  output logic [3:0] prled
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  // long_press is registered together with the hold counter, so it is armed
  // one count early and lands on the cycle the counter shows LONG_CYCLES-1.
  localparam logic [HOLD_W-1:0] HOLD_ARM = HOLD_W'(LONG_CYCLES - 2);

  logic btn_sync;
  logic act;

  sync2 #(.RESET_VALUE(1'b1)) u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (btn_n),
    .q   (btn_sync)
  );

  assign act = ~btn_sync;

  state_t              state_reg,   state_next;
  logic [DB_W-1:0]     db_cnt_reg,  db_cnt_next;
  logic [HOLD_W-1:0]   hold_reg,    hold_next;
  logic                level_reg,   level_next;
  logic                press_reg,   press_next;
  logic                release_reg, release_next;
  logic                long_reg,    long_next;
  logic [3:0]          count_reg,   count_next;
  logic [3:0]          prled_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      db_cnt_reg  <= '0;
      hold_reg    <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      long_reg    <= 1'b0;
      count_reg   <= 4'd0;
      prled_reg   <= 4'b1111;
    end else begin
      state_reg   <= state_next;
      db_cnt_reg  <= db_cnt_next;
      hold_reg    <= hold_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      long_reg    <= long_next;
      count_reg   <= count_next;
      prled_reg   <= ~count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    db_cnt_next  = db_cnt_reg;
    hold_next    = hold_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    count_next   = count_reg;

    // The hold counter keeps running across a release bounce so a glitchy
    // hold still produces its long_press.
    if (state_reg == PRESSED || state_reg == RELEASE_WAIT) begin
      if (hold_reg != HOLD_MAX) begin
        hold_next = hold_reg + HOLD_W'(1);
      end
      long_next = (hold_reg == HOLD_ARM);
    end

    case (state_reg)
      IDLE: begin
        if (act) begin
          state_next  = PRESS_WAIT;
          db_cnt_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (!act) begin
          state_next = IDLE;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next = PRESSED;
          level_next = 1'b1;
          press_next = 1'b1;
          count_next = count_reg + 4'd1;
          hold_next  = '0;
        end else begin
          db_cnt_next = db_cnt_reg + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!act) begin
          state_next  = RELEASE_WAIT;
          db_cnt_next = '0;
        end
      end
      RELEASE_WAIT: begin
        if (act) begin
          state_next = PRESSED;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next   = IDLE;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          db_cnt_next = db_cnt_reg + DB_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign btn_level     = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign long_press    = long_reg;
  assign press_count   = count_reg;
  assign prled         = prled_reg;

endmodule
